vga_scanout: RTL and testbench

- Read-side counterpart of the VRAM writer. Generates 640x480@60 VGA timing.
- Reads VRAM pixel bytes from the same {y[9:0], x[9:0]} address map the writer uses (RGB332, 8 bits per pixel).
- Drives pixel, hsync, vsync and display-enable, all aligned to each other.
- Sits between the VRAM read port and the board DAC/pins; runs on the pixel clock.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_timing.sv | 70 +++++++
 rtl/vga_scanout.sv | 145 ++++++++++++++
 tb/tb_vga_scanout.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared pixel/address types, 640x480@60 timing constants and colour-bar
// helpers for the VGA scanout path.
package vga_pkg;

    typedef logic [7:0]  rgb332_t;
    typedef logic [19:0] vram_addr_t;

    localparam int unsigned VGA_H_VISIBLE = 640;
    localparam int unsigned VGA_H_FRONT   = 16;
    localparam int unsigned VGA_H_SYNC    = 96;
    localparam int unsigned VGA_H_BACK    = 48;
    localparam int unsigned VGA_V_VISIBLE = 480;
    localparam int unsigned VGA_V_FRONT   = 10;
    localparam int unsigned VGA_V_SYNC    = 2;
    localparam int unsigned VGA_V_BACK    = 33;

    localparam int unsigned H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam rgb332_t BLANK_COLOR = 8'h00;

    // Raw raster flags carried down the read-latency pipeline.
    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
        logic first;
    } scan_flags_t;

    // Bar number = h / 80, done as a compare chain rather than a divider.
    function automatic logic [2:0] bar_index(input logic [9:0] h);
        logic [2:0] bar;
        bar = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h >= 10'(i * 80)) bar = 3'(i);
        end
        return bar;
    endfunction

    function automatic rgb332_t bar_color(input logic [2:0] bar);
        return {bar[2], bar[2], bar[2], bar[1], bar[1], bar[1], bar[0], bar[0]};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus the raw visible / sync / first-pixel flags decoded
// straight from the counter registers.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    output logic [9:0] h_count_o,
    output logic [9:0] v_count_o,
    output logic       visible_o,
    output logic       hsync_act_o,
    output logic       vsync_act_o,
    output logic       first_px_o
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    // Disabled scanning parks the raster at the origin.
    always_comb begin
        h_d = '0;
        v_d = '0;
        if (enable_i) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
                v_d = v_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_count_o   = h_q;
    assign v_count_o   = v_q;
    assign visible_o   = (h_q < H_VIS) && (v_q < V_VIS);
    assign hsync_act_o = (h_q >= HS_START) && (h_q <= HS_END);
    assign vsync_act_o = (v_q >= VS_START) && (v_q <= VS_END);
    assign first_px_o  = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: VRAM read addressing, read-latency alignment pipeline and the
// registered pixel/sync outputs. VGA_SCANOUT_TEST_PATTERN_EN adds colour bars.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE        = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT          = VGA_H_FRONT,
    parameter int unsigned H_SYNC           = VGA_H_SYNC,
    parameter int unsigned H_BACK           = VGA_H_BACK,
    parameter int unsigned V_VISIBLE        = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT          = VGA_V_FRONT,
    parameter int unsigned V_SYNC           = VGA_V_SYNC,
    parameter int unsigned V_BACK           = VGA_V_BACK,
    parameter int unsigned SYNC_ACTIVE_HIGH = 0,
    parameter int unsigned READ_LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic        test_pattern,
`endif
    output logic [19:0] vram_address,
    output logic        vram_read_en,
    input  logic [7:0]  vram_data,
    output logic [7:0]  pixel,
    output logic        display_en,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    logic [9:0]  h_count, v_count;
    logic        visible, hs_act, vs_act, first_px;
    scan_flags_t flags_in, flags_dly;
    scan_flags_t flags_q [READ_LATENCY];
    rgb332_t     pixel_d, pixel_q;
    logic        de_q, hs_q, vs_q, fs_q;
    logic        scan_vis;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .h_count_o   (h_count),
        .v_count_o   (v_count),
        .visible_o   (visible),
        .hsync_act_o (hs_act),
        .vsync_act_o (vs_act),
        .first_px_o  (first_px)
    );

    // Counters lag enable by one edge, so gate with enable to blank at once.
    assign scan_vis     = enable && visible;
    assign vram_address = scan_vis ? {v_count, h_count} : '0;

    always_comb begin
        flags_in = '0;
        if (enable) begin
            flags_in.visible = visible;
            flags_in.hsync   = hs_act;
            flags_in.vsync   = vs_act;
            flags_in.first   = first_px;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) flags_q[i] <= '0;
        end else begin
            flags_q[0] <= flags_in;
            for (int unsigned i = 1; i < READ_LATENCY; i++) flags_q[i] <= flags_q[i-1];
        end
    end

    assign flags_dly = flags_q[READ_LATENCY-1];

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [3:0] pat_q [READ_LATENCY];
    logic [3:0] pat_dly;

    assign vram_read_en = scan_vis && !test_pattern;

    // Bar index travels alongside the flags so it lines up with vram_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) pat_q[i] <= '0;
        end else begin
            pat_q[0] <= {test_pattern, bar_index(h_count)};
            for (int unsigned i = 1; i < READ_LATENCY; i++) pat_q[i] <= pat_q[i-1];
        end
    end

    assign pat_dly = pat_q[READ_LATENCY-1];

    always_comb begin
        pixel_d = BLANK_COLOR;
        if (flags_dly.visible) begin
            pixel_d = pat_dly[3] ? bar_color(pat_dly[2:0]) : vram_data;
        end
    end
`else
    assign vram_read_en = scan_vis;

    always_comb begin
        pixel_d = BLANK_COLOR;
        if (flags_dly.visible) pixel_d = vram_data;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q <= BLANK_COLOR;
            de_q    <= 1'b0;
            hs_q    <= SYNC_OFF;
            vs_q    <= SYNC_OFF;
            fs_q    <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            de_q    <= flags_dly.visible;
            hs_q    <= flags_dly.hsync ? SYNC_ON : SYNC_OFF;
            vs_q    <= flags_dly.vsync ? SYNC_ON : SYNC_OFF;
            fs_q    <= flags_dly.first;
        end
    end

    assign pixel       = pixel_q;
    assign display_en  = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full-size 640x480 instance (latency 1, active-low
// syncs) and a shrunken raster (latency 3, active-high syncs) side by side.
module tb_vga_scanout;

    typedef struct packed {
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] pix;
    } out_t;

    typedef struct {
        int unsigned h;
        int unsigned v;
        bit          de;
        bit          hs;
        bit          fs;
        logic [7:0]  pix;
    } vec_t;

    // Index 0 = full-size instance, 1 = shrunken raster.
    int unsigned HV  [2] = '{640, 16};
    int unsigned VV  [2] = '{480, 8};
    int unsigned HT  [2] = '{800, 30};
    int unsigned VT  [2] = '{525, 15};
    int unsigned HS0 [2] = '{656, 19};
    int unsigned HS1 [2] = '{751, 23};
    int unsigned VS0 [2] = '{490, 10};
    int unsigned VS1 [2] = '{491, 11};
    int unsigned LAT [2] = '{1, 3};
    bit          ACT [2] = '{1'b0, 1'b1};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic test_pattern = 1'b0;

    logic [19:0] addr1, addr3;
    logic        ren1, ren3;
    logic [7:0]  vd1, vd3, pix1, pix3;
    logic        de1, hs1, vs1, fs1, de3, hs3, vs3, fs3;
    logic [7:0]  vp3 [3];

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;
    int unsigned ecount = 0;

    int unsigned pos [2];
    out_t        exp_out [2];
    out_t        mq [2][$];

    always #5 clk = ~clk;

    vga_scanout #(.READ_LATENCY(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .vram_address (addr1),
        .vram_read_en (ren1),
        .vram_data    (vd1),
        .pixel        (pix1),
        .display_en   (de1),
        .hsync        (hs1),
        .vsync        (vs1),
        .frame_start  (fs1)
    );

    vga_scanout #(
        .H_VISIBLE(16), .H_FRONT(3), .H_SYNC(5), .H_BACK(6),
        .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_HIGH(1), .READ_LATENCY(3)
    ) dut3 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .vram_address (addr3),
        .vram_read_en (ren3),
        .vram_data    (vd3),
        .pixel        (pix3),
        .display_en   (de3),
        .hsync        (hs3),
        .vsync        (vs3),
        .frame_start  (fs3)
    );

    function automatic logic [7:0] vram_fn(input int d, input logic [19:0] a);
        if (d == 0) return a[7:0];
        return a[7:0] ^ {a[12:10], 5'b0};
    endfunction

    function automatic logic [7:0] bar_col(input int unsigned b);
        logic [2:0] x;
        x = 3'(b);
        return {{3{x[2]}}, {3{x[1]}}, {2{x[0]}}};
    endfunction

    // VRAM models; unread cycles return noise that must never reach the pixel.
    always_ff @(posedge clk) begin
        vd1    <= ren1 ? vram_fn(0, addr1) : 8'($urandom);
        vp3[0] <= ren3 ? vram_fn(1, addr3) : 8'($urandom);
        vp3[1] <= vp3[0];
        vp3[2] <= vp3[1];
    end
    assign vd3 = vp3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0;
            mq[d].delete();
            for (int unsigned k = 0; k < LAT[d]; k++) mq[d].push_back('0);
            exp_out[d] = '0;
        end
    endtask

    // Raster position is a plain cycle index; what it shows emerges LAT+1 edges later.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int unsigned h = pos[d] % HT[d];
            int unsigned v = pos[d] / HT[d];
            out_t e = '0;
            if (enable) begin
                e.de = (h < HV[d]) && (v < VV[d]);
                e.hs = (h >= HS0[d]) && (h <= HS1[d]);
                e.vs = (v >= VS0[d]) && (v <= VS1[d]);
                e.fs = (pos[d] == 0);
                if (e.de) e.pix = test_pattern ? bar_col(h / 80) : vram_fn(d, {10'(v), 10'(h)});
            end
            mq[d].push_back(e);
            exp_out[d] = mq[d].pop_front();
            pos[d] = enable ? (pos[d] + 1) % (HT[d] * VT[d]) : 0;
        end
    endtask

    task automatic sb_compare(input int d, input out_t act, input logic ren, input logic [19:0] addr);
        int unsigned h = pos[d] % HT[d];
        int unsigned v = pos[d] / HT[d];
        logic vis = enable && (h < HV[d]) && (v < VV[d]);
        out_t e = exp_out[d];
        logic [19:0] ea = vis ? {10'(v), 10'(h)} : '0;
        logic eren = vis && !test_pattern;
        logic hl = e.hs ? ACT[d] : !ACT[d];
        logic vl = e.vs ? ACT[d] : !ACT[d];
        check(d == 0 ? "sb_dut1" : "sb_dut3",
              {31'd0, act, ren, addr},
              {31'd0, e.de, hl, vl, e.fs, e.pix, eren, ea});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            sb_compare(0, {de1, hs1, vs1, fs1, pix1}, ren1, addr1);
            sb_compare(1, {de3, hs3, vs3, fs3, pix3}, ren3, addr3);
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ecount++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        ecount = 0;
        chk_on = 1'b1;
    endtask

    vec_t tbl [14];
    int unsigned de_c1 [3];
    int unsigned hs_c1 [3];
    int unsigned de_c3 [5];
    int unsigned vs_c3 [5];
    int unsigned first1, first3, r;

    initial begin
        tbl[0]  = '{0,   0, 1, 0, 1, 8'h00};
        tbl[1]  = '{5,   0, 1, 0, 0, 8'h05};
        tbl[2]  = '{255, 0, 1, 0, 0, 8'hFF};
        tbl[3]  = '{256, 0, 1, 0, 0, 8'h00};
        tbl[4]  = '{639, 0, 1, 0, 0, 8'h7F};
        tbl[5]  = '{640, 0, 0, 0, 0, 8'h00};
        tbl[6]  = '{655, 0, 0, 0, 0, 8'h00};
        tbl[7]  = '{656, 0, 0, 1, 0, 8'h00};
        tbl[8]  = '{751, 0, 0, 1, 0, 8'h00};
        tbl[9]  = '{752, 0, 0, 0, 0, 8'h00};
        tbl[10] = '{799, 0, 0, 0, 0, 8'h00};
        tbl[11] = '{0,   1, 1, 0, 0, 8'h00};
        tbl[12] = '{5,   3, 1, 0, 0, 8'h05};
        tbl[13] = '{100, 3, 1, 0, 0, 8'h64};

        // Table: full-size raster positions seen two clocks after the counters.
        enable = 1'b1;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            while (ecount < tbl[i].v * 800 + tbl[i].h + 2) tick(1);
            #3;
            check("tbl_pix", 64'(pix1), 64'(tbl[i].pix));
            check("tbl_de",  64'(de1),  64'(tbl[i].de));
            check("tbl_hs",  64'(hs1),  64'(!tbl[i].hs));
            check("tbl_vs",  64'(vs1),  64'(1'b1));
            check("tbl_fs",  64'(fs1),  64'(tbl[i].fs));
        end

        // Per-line / per-frame pulse widths and the (5,3) address-to-pixel path.
        do_reset();
        for (int l = 0; l < 3; l++) begin de_c1[l] = 0; hs_c1[l] = 0; end
        for (int f = 0; f < 5; f++) begin de_c3[f] = 0; vs_c3[f] = 0; end
        for (int unsigned n = 1; n <= 2600; n++) begin
            tick(1);
            #3;
            if (n >= 2 && n < 2402) begin
                de_c1[(n-2)/800] += de1;
                hs_c1[(n-2)/800] += !hs1;
            end
            if (n >= 4 && n < 4 + 2250) begin
                de_c3[(n-4)/450] += de3;
                vs_c3[(n-4)/450] += vs3;
            end
            if (n == 2405) begin
                check("addr_5_3", 64'(addr1), 64'h00C05);
                check("ren_5_3",  64'(ren1),  64'(1'b1));
            end
            if (n == 2407) check("pix_5_3", 64'(pix1), 64'h05);
        end
        for (int l = 0; l < 3; l++) begin
            check("de_per_line", 64'(de_c1[l]), 64'd640);
            check("hs_per_line", 64'(hs_c1[l]), 64'd96);
        end
        for (int f = 0; f < 5; f++) begin
            check("de_per_frame3", 64'(de_c3[f]), 64'd128);
            check("vs_per_frame3", 64'(vs_c3[f]), 64'd60);
        end

        // frame_start latency from reset release.
        do_reset();
        for (int unsigned n = 1; n <= 5; n++) begin
            tick(1);
            #3;
            check("fs1_after_reset", 64'(fs1), 64'(n == 2));
            check("fs3_after_reset", 64'(fs3), 64'(n == 4));
        end

        // Enable drop mid-line, blanking latency, restart latency.
        do_reset();
        while (ecount < 1100) tick(1);
        enable = 1'b0;
        #3;
        check("drop_ren1", 64'(ren1), 64'(1'b0));
        check("drop_addr1", 64'(addr1), 64'd0);
        for (int unsigned k = 1; k <= 10; k++) begin
            tick(1);
            #3;
            if (k == 1) begin
                check("drop_de1_k1", 64'(de1), 64'(1'b1));
                check("drop_pix1_k1", 64'(pix1), 64'h2B);
            end
            if (k == 2) check("drop_out1", {32'd0, 19'd0, pix1, de1, hs1, vs1, fs1, 1'b0}, {32'd0, 19'd0, 8'h00, 4'b0110, 1'b0});
            if (k == 4) check("drop_out3", {32'd0, 19'd0, pix3, de3, hs3, vs3, fs3, 1'b0}, {32'd0, 19'd0, 8'h00, 4'b0000, 1'b0});
        end
        enable = 1'b1;
        first1 = 0;
        first3 = 0;
        for (int unsigned n = 1; n <= 8; n++) begin
            tick(1);
            #3;
            if (fs1 && first1 == 0) first1 = n;
            if (fs3 && first3 == 0) first3 = n;
        end
        check("restart_fs1", 64'(first1), 64'd2);
        check("restart_fs3", 64'(first3), 64'd4);

        // Asynchronous reset between clock edges.
        do_reset();
        tick(500);
        #1 rst = 1'b1;
        #1;
        check("arst_out1", {32'd0, 19'd0, pix1, de1, hs1, vs1, fs1, 1'b0}, {32'd0, 19'd0, 8'h00, 4'b0110, 1'b0});
        check("arst_out3", {32'd0, 19'd0, pix3, de3, hs3, vs3, fs3, 1'b0}, {32'd0, 19'd0, 8'h00, 4'b0000, 1'b0});
        check("arst_addr1", 64'(addr1), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        ecount = 0;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        test_pattern = 1'b1;
        do_reset();
        for (int unsigned n = 1; n <= 642; n++) begin
            tick(1);
            #3;
            check("tp_ren1", 64'(ren1), 64'(1'b0));
            if (n >= 2 && n < 82)   check("tp_bar0", 64'(pix1), 64'h00);
            if (n >= 82 && n < 162) check("tp_bar1", 64'(pix1), 64'h03);
            if (n >= 562 && n < 642) check("tp_bar7", 64'(pix1), 64'hFF);
        end
        test_pattern = 1'b0;
`endif

        // Random enable/reset/pattern activity against the reference model.
        do_reset();
        for (int i = 0; i < 30000; i++) begin
            tick(1);
            r = $urandom_range(0, 999);
            if (enable) begin
                if (r < 2) enable = 1'b0;
            end else if (r < 100) begin
                enable = 1'b1;
            end
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            if (r >= 990 && r < 994) test_pattern = !test_pattern;
`endif
            if (r == 999) begin
                #1 rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #2 rst = 1'b0;
            end
        end

        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
